// File: rtl/sdp_ram_pkg.sv
// Shared definitions for the simple dual-port RAM responder: default
// geometry, counter width and the two-state controller encoding.
package sdp_ram_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 10;
    localparam int DEPTH      = 1 << ADDR_W_DEF;
    localparam int CNT_W      = 16;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

endpackage

// File: rtl/sdp_ram_core.sv
// Storage array: one write port and one registered read port, no reset,
// so the array and its read register map onto a block RAM. The read
// register only loads when a read is enabled, so it holds otherwise.
// A same-address read and write return the old contents (read-first).
module sdp_ram_core
    import sdp_ram_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] r_rdata;

    // Write port and registered read port on the same edge.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/sdp_ram_responder.sv
// Simple dual-port RAM responder. After reset the controller sweeps the
// whole array writing zero (busy=1); user reads/writes are then accepted
// and counted. Optional macro RAM_BYPASS_EN makes a same-address
// read-during-write return the new write data instead of the old word.
module sdp_ram_responder
    import sdp_ram_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data,
    input  logic [ADDR_W-1:0] wraddress,
    input  logic              wren,
    input  logic [ADDR_W-1:0] rdaddress,
    input  logic              rden,
    output logic [DATA_W-1:0] q,
    output logic              q_valid,
    output logic              busy,
    output logic [CNT_W-1:0]  wr_cnt,
    output logic [CNT_W-1:0]  rd_cnt
);

    localparam int LDEPTH = 1 << ADDR_W;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_clr_addr;
    logic              w_init;
    logic              w_clr_last;
    logic              w_wr_acc;
    logic              w_rd_acc;
    logic              w_core_we;
    logic [ADDR_W-1:0] w_core_waddr;
    logic [DATA_W-1:0] w_core_wdata;
    logic [DATA_W-1:0] w_core_q;
    logic [DATA_W-1:0] w_rd_word;
    logic              r_q_zero;
    logic              r_q_valid;
    logic [CNT_W-1:0]  r_wr_cnt;
    logic [CNT_W-1:0]  r_rd_cnt;

    assign w_init     = (r_state == INIT);
    assign w_clr_last = (r_clr_addr == ADDR_W'(LDEPTH - 1));
    assign w_wr_acc   = (r_state == READY) && wren;
    assign w_rd_acc   = (r_state == READY) && rden;

    // Controller state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: leave INIT on the cycle that clears the last address.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            INIT:    if (w_clr_last) w_state_nxt = READY;
            READY:   w_state_nxt = READY;
            default: w_state_nxt = INIT;
        endcase
    end

    // Clear-sweep address, restarted from zero by every reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clr_addr <= '0;
        end else if (w_init) begin
            r_clr_addr <= r_clr_addr + ADDR_W'(1);
        end
    end

    // The write port belongs to the clear sweep while initialising.
    assign w_core_we    = w_init || w_wr_acc;
    assign w_core_waddr = w_init ? r_clr_addr : wraddress;
    assign w_core_wdata = w_init ? '0 : data;

    sdp_ram_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_core (
        .clk     (clk),
        .i_we    (w_core_we),
        .i_waddr (w_core_waddr),
        .i_wdata (w_core_wdata),
        .i_re    (w_rd_acc),
        .i_raddr (rdaddress),
        .o_rdata (w_core_q)
    );

`ifdef RAM_BYPASS_EN
    logic              r_byp_hit;
    logic [DATA_W-1:0] r_byp_data;

    // Remember whether the accepted read collided with a write, and the data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byp_hit <= 1'b0;
        end else if (w_rd_acc) begin
            r_byp_hit <= w_wr_acc && (wraddress == rdaddress);
        end
    end

    // Captured write data for the bypass path; carries no reset.
    always_ff @(posedge clk) begin
        if (w_rd_acc) begin
            r_byp_data <= data;
        end
    end

    assign w_rd_word = r_byp_hit ? r_byp_data : w_core_q;
`else
    assign w_rd_word = w_core_q;
`endif

    // The RAM read register cannot be reset, so a flag masks q to zero
    // from reset until the first accepted read reloads it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q_zero  <= 1'b1;
            r_q_valid <= 1'b0;
        end else begin
            r_q_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_q_zero <= 1'b0;
            end
        end
    end

    // Accepted-transfer statistics, wrapping naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
        end else begin
            if (w_wr_acc) r_wr_cnt <= r_wr_cnt + CNT_W'(1);
            if (w_rd_acc) r_rd_cnt <= r_rd_cnt + CNT_W'(1);
        end
    end

    assign q       = r_q_zero ? '0 : w_rd_word;
    assign q_valid = r_q_valid;
    assign busy    = w_init;
    assign wr_cnt  = r_wr_cnt;
    assign rd_cnt  = r_rd_cnt;

endmodule

// File: tb/tb_sdp_ram_responder.sv
// Self-checking bench for sdp_ram_responder: directed vector table plus
// hand-written sequences for init, reset-during-burst and counter wrap.
// Honours RAM_BYPASS_EN for the collision expectation.
module tb_sdp_ram_responder;

    logic        clk;
    logic        rst_n;
    logic [15:0] data;
    logic [9:0]  wraddress;
    logic        wren;
    logic [9:0]  rdaddress;
    logic        rden;
    logic [15:0] q;
    logic        q_valid;
    logic        busy;
    logic [15:0] wr_cnt;
    logic [15:0] rd_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] exp_wr = 16'd0;
    logic [15:0] exp_rd = 16'd0;

`ifdef RAM_BYPASS_EN
    localparam logic [15:0] COLL_EXP = 16'hABCD;
`else
    localparam logic [15:0] COLL_EXP = 16'h1111;
`endif

    typedef struct {
        logic        wr;
        logic [9:0]  wa;
        logic [15:0] wd;
        logic        rd;
        logic [9:0]  ra;
        logic        exp_qv;
        logic        chk_q;
        logic [15:0] exp_q;
    } vec_t;

    vec_t vecs[$];

    sdp_ram_responder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data      (data),
        .wraddress (wraddress),
        .wren      (wren),
        .rdaddress (rdaddress),
        .rden      (rden),
        .q         (q),
        .q_valid   (q_valid),
        .busy      (busy),
        .wr_cnt    (wr_cnt),
        .rd_cnt    (rd_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wren = 1'b0; rden = 1'b0; data = '0; wraddress = '0; rdaddress = '0;
    endtask

    task automatic add(input logic wr, input logic [9:0] wa, input logic [15:0] wd,
                       input logic rd, input logic [9:0] ra,
                       input logic eqv, input logic cq, input logic [15:0] eq);
        vec_t v;
        v.wr = wr; v.wa = wa; v.wd = wd; v.rd = rd; v.ra = ra;
        v.exp_qv = eqv; v.chk_q = cq; v.exp_q = eq;
        vecs.push_back(v);
    endtask

    // Count cycles with busy high after reset release; optionally drive
    // writes/reads into the sweep and confirm they are ignored.
    task automatic wait_init(input bit poke, input string name);
        int n;
        int bad;
        n = 0;
        bad = 0;
        if (poke) begin
            wren = 1'b1; wraddress = 10'd3; data = 16'h5555;
            rden = 1'b1; rdaddress = 10'd3;
        end
        do begin
            step();
            n++;
            if (poke && n <= 500) begin
                if (q_valid !== 1'b0 || wr_cnt !== 16'd0 || rd_cnt !== 16'd0) bad++;
                if (n == 500) idle_inputs();
            end
        end while (busy && n < 2000);
        chk({name, "_busy_cycles"}, n, 1024);
        if (poke) chk({name, "_ignored"}, bad, 0);
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        #3;
        chk("rst_q",      q,       0);
        chk("rst_qv",     q_valid, 0);
        chk("rst_busy",   busy,    1);
        chk("rst_wr_cnt", wr_cnt,  0);
        chk("rst_rd_cnt", rd_cnt,  0);
        step();
        rst_n = 1'b1;
        wait_init(1'b1, "init1");
        chk("post_init_wr_cnt", wr_cnt, 0);
        chk("post_init_rd_cnt", rd_cnt, 0);

        // wr  wa  wd  rd  ra  qv chkq q
        add(0, 0, 0, 1, 5, 1, 1, 16'h0000);
        add(0, 0, 0, 1, 3, 1, 1, 16'h0000);
        for (int i = 20; i <= 30; i++) add(1, 10'(i), 16'(i), 0, 0, 0, 0, 0);
        for (int i = 20; i <= 30; i++) add(0, 0, 0, 1, 10'(i), 1, 1, 16'(i));
        add(0, 0, 0, 0, 0, 0, 1, 16'd30);
        add(1, 7, 16'h1111, 0, 0, 0, 1, 16'd30);
        add(1, 7, 16'hABCD, 1, 7, 1, 1, COLL_EXP);
        add(0, 0, 0, 1, 7, 1, 1, 16'hABCD);
        add(1, 40, 16'h4040, 1, 20, 1, 1, 16'd20);
        add(0, 0, 0, 1, 40, 1, 1, 16'h4040);
        add(0, 0, 0, 0, 0, 0, 1, 16'h4040);

        foreach (vecs[k]) begin
            wren = vecs[k].wr; wraddress = vecs[k].wa; data = vecs[k].wd;
            rden = vecs[k].rd; rdaddress = vecs[k].ra;
            step();
            if (vecs[k].wr) exp_wr++;
            if (vecs[k].rd) exp_rd++;
            chk($sformatf("vec%0d_qv", k), q_valid, vecs[k].exp_qv);
            if (vecs[k].chk_q) chk($sformatf("vec%0d_q", k), q, vecs[k].exp_q);
        end
        idle_inputs();
        chk("table_wr_cnt", wr_cnt, exp_wr);
        chk("table_rd_cnt", rd_cnt, exp_rd);

        // Reset in the middle of a read burst.
        for (int i = 20; i < 24; i++) begin
            rden = 1'b1; rdaddress = 10'(i);
            step();
        end
        chk("burst_q_before_rst", q, 23);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_q",      q,       0);
        chk("midrst_qv",     q_valid, 0);
        chk("midrst_wr_cnt", wr_cnt,  0);
        chk("midrst_rd_cnt", rd_cnt,  0);
        chk("midrst_busy",   busy,    1);
        idle_inputs();
        step();
        rst_n = 1'b1;
        exp_wr = 0;
        exp_rd = 0;
        wait_init(1'b0, "init2");

        rden = 1'b1; rdaddress = 10'd20;
        step();
        idle_inputs();
        chk("reinit_read20_q",  q,       0);
        chk("reinit_read20_qv", q_valid, 1);
        step();
        chk("idle_qv", q_valid, 0);

        // Drive wr_cnt up to FFFF, then one more write must wrap it.
        while (exp_wr != 16'hFFFF) begin
            wren = 1'b1; wraddress = 10'd100; data = exp_wr;
            step();
            exp_wr++;
        end
        wren = 1'b0;
        chk("wr_cnt_ffff", wr_cnt, 16'hFFFF);
        wren = 1'b1; wraddress = 10'd100; data = 16'h7777;
        step();
        idle_inputs();
        chk("wr_cnt_wrap", wr_cnt, 16'h0000);
        rden = 1'b1; rdaddress = 10'd100;
        step();
        idle_inputs();
        chk("last_write_q", q, 16'h7777);
        chk("final_rd_cnt", rd_cnt, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
